// File: rtl/seg_display_pkg.sv
// Shared constants, segment encoder and FSM state codes for seg_scan_display.
package seg_display_pkg;

    // Active-low 7-segment codes for hex digits 0..F (bit7 = dp, always off)
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e
    };
    localparam logic [7:0] SEG_DASH  = 8'hbf;
    localparam logic [7:0] SEG_BLANK = 8'hff;

    // Handshake/conversion FSM state codes
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_CONV = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    // Nibble to active-low segment code
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: DATA_W shift cycles into a
// 4*NUM_DIGITS-bit BCD field, with a sticky overflow of bits shifted out.
module bin2bcd_seq #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_W-1:0]       bin,
    output logic                    busy,
    output logic                    done_c,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh;
    logic [CNT_W-1:0]  cnt;
    logic [BCD_W-1:0]  adj_c;

    // Add 3 to every BCD digit that is 5 or more before the shift
    always_comb begin
        adj_c = bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // High during the cycle whose edge performs the final shift
    assign done_c = busy && (cnt == CNT_W'(DATA_W - 1));

    // Load, shift and overflow tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            bcd  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b0;
            cnt  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start && !busy) begin
            sh   <= bin;
            bcd  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            bcd <= {adj_c[BCD_W-2:0], sh[DATA_W-1]};
            ovf <= ovf | adj_c[BCD_W-1];
            sh  <= sh << 1;
            cnt <= cnt + CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver showing a handshaked binary value in hex
// or decimal. Optional macro SEG_LZ_BLANK_EN blanks leading zeros in decimal.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SCAN_CNT_MAX = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  start,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  dec_mode,
    output logic [NUM_DIGITS-1:0] led_en,
    output logic [7:0]            led_w
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned PAD_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int unsigned POS_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = (SCAN_CNT_MAX > 1) ? $clog2(SCAN_CNT_MAX) : 1;

    fsm_state_t            state, state_nxt;
    logic                  on;
    logic [CNT_W-1:0]      scan_cnt;
    logic [POS_W-1:0]      scan_pos;
    logic [3:0]            buf_dig [NUM_DIGITS];
    logic                  buf_dash;
    logic                  buf_dec;
    logic                  xfer_c, conv_start_c, hex_load_c, dec_load_c, buf_clr_c;
    logic                  abort_c;
    logic                  conv_busy, conv_done_c, conv_ovf;
    logic [BCD_W-1:0]      conv_bcd;
    logic [PAD_W-1:0]      din_pad;
    logic [NUM_DIGITS-1:0] blank_c;
    logic [7:0]            seg_c;

    assign data_ready = !rst && locked && (state == ST_IDLE);
    assign xfer_c     = data_valid && data_ready;
    assign abort_c    = !locked;
    assign din_pad    = PAD_W'(data_in);

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (conv_start_c),
        .abort  (abort_c),
        .bin    (data_in),
        .busy   (conv_busy),
        .done_c (conv_done_c),
        .bcd    (conv_bcd),
        .ovf    (conv_ovf)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and buffer write strobes; losing lock aborts any conversion
    always_comb begin
        state_nxt    = state;
        conv_start_c = 1'b0;
        hex_load_c   = 1'b0;
        dec_load_c   = 1'b0;
        buf_clr_c    = 1'b0;
        if (!locked) begin
            state_nxt = ST_IDLE;
            buf_clr_c = (state != ST_IDLE);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer_c) begin
                        if (dec_mode) begin
                            conv_start_c = 1'b1;
                            state_nxt    = ST_CONV;
                        end else begin
                            hex_load_c = 1'b1;
                        end
                    end
                end
                ST_CONV: begin
                    // idle converter here would mean a lost start; do not hang
                    if (conv_done_c || !conv_busy) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    dec_load_c = 1'b1;
                    state_nxt  = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Display buffer: hex written at transfer, decimal written whole in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) buf_dig[i] <= 4'd0;
            buf_dash <= 1'b0;
            buf_dec  <= 1'b0;
        end else if (buf_clr_c) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) buf_dig[i] <= 4'd0;
            buf_dash <= 1'b0;
            buf_dec  <= 1'b0;
        end else if (hex_load_c) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) buf_dig[i] <= din_pad[4*i +: 4];
            buf_dash <= 1'b0;
            buf_dec  <= 1'b0;
        end else if (dec_load_c) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) buf_dig[i] <= conv_bcd[4*i +: 4];
            buf_dash <= conv_ovf;
            buf_dec  <= 1'b1;
        end
    end

    // Display-on flag; lock loss dominates start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on <= 1'b0;
        end else if (!locked) begin
            on <= 1'b0;
        end else if (start) begin
            on <= 1'b1;
        end
    end

    // Slot timer and digit position, held at zero while off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_pos <= '0;
        end else if (!on) begin
            scan_cnt <= '0;
            scan_pos <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_CNT_MAX - 1)) begin
            scan_cnt <= '0;
            scan_pos <= (scan_pos == POS_W'(NUM_DIGITS - 1)) ? '0 : scan_pos + POS_W'(1);
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // Leading-zero mask for decimal values (digit 0 always shown)
    always_comb begin
        blank_c = '0;
`ifdef SEG_LZ_BLANK_EN
        if (buf_dec && !buf_dash) begin
            logic lead;
            lead = 1'b1;
            for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
                if (buf_dig[i] != 4'd0) lead = 1'b0;
                blank_c[i] = lead;
            end
        end
`endif
    end

    // Segment code for the digit at the current scan position
    always_comb begin
        if (buf_dash) begin
            seg_c = SEG_DASH;
        end else if (blank_c[scan_pos]) begin
            seg_c = SEG_BLANK;
        end else begin
            seg_c = hex_to_seg(buf_dig[scan_pos]);
        end
    end

    // Registered pins; lock loss blanks on the same edge that clears on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en <= '1;
            led_w  <= SEG_BLANK;
        end else if (!on || !locked) begin
            led_en <= '1;
            led_w  <= SEG_BLANK;
        end else begin
            led_en <= ~(NUM_DIGITS'(1) << scan_pos);
            led_w  <= seg_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: an 8-digit and a 6-digit instance
// share all inputs so the non-power-of-2 scan runs in lockstep.
module tb_seg_scan_display;

    logic        clk;
    logic        rst;
    logic        locked;
    logic        start;
    logic        data_valid;
    logic [31:0] data_in;
    logic        dec_mode;
    logic        data_ready;
    logic [7:0]  led_en;
    logic [7:0]  led_w;
    logic        data_ready6;
    logic [5:0]  led_en6;
    logic [7:0]  led_w6;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seen8 [8];
    logic [7:0] seen6 [6];

`ifdef SEG_LZ_BLANK_EN
    localparam logic [7:0] LZ = 8'hff;
`else
    localparam logic [7:0] LZ = 8'hc0;
`endif

    seg_scan_display #(.NUM_DIGITS(8), .DATA_W(32), .SCAN_CNT_MAX(5)) dut (
        .clk(clk), .rst(rst), .locked(locked), .start(start),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .dec_mode(dec_mode), .led_en(led_en), .led_w(led_w)
    );

    seg_scan_display #(.NUM_DIGITS(6), .DATA_W(32), .SCAN_CNT_MAX(5)) dut6 (
        .clk(clk), .rst(rst), .locked(locked), .start(start),
        .data_valid(data_valid), .data_ready(data_ready6), .data_in(data_in),
        .dec_mode(dec_mode), .led_en(led_en6), .led_w(led_w6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Offer one word and hold it until accepted (bounded)
    task automatic send(input logic [31:0] v, input logic dm);
        int n;
        data_valid = 1'b1;
        data_in    = v;
        dec_mode   = dm;
        n = 0;
        while (!data_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL send_accept: data_ready stayed %b, required 1", data_ready);
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    // Wait for the block to return to IDLE (bounded)
    task automatic wait_ready();
        int n;
        n = 0;
        while (!data_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL wait_ready: data_ready stayed %b, required 1", data_ready);
        end
        @(posedge clk); #1;
    endtask

    // Record the last segment code seen on each digit over a full scan
    task automatic capture();
        for (int i = 0; i < 8; i++) seen8[i] = 8'h00;
        for (int i = 0; i < 6; i++) seen6[i] = 8'h00;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 8; i++) if (led_en == ~(8'(1) << i)) seen8[i] = led_w;
            for (int i = 0; i < 6; i++) if (led_en6 == ~(6'(1) << i)) seen6[i] = led_w6;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; locked = 1'b1; start = 1'b0;
        data_valid = 1'b0; data_in = '0; dec_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (led_en !== 8'hff) begin n_fail++; $display("FAIL reset_led_en: got %h required ff", led_en); end
        if (led_w !== 8'hff) begin n_fail++; $display("FAIL reset_led_w: got %h required ff", led_w); end
        if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", data_ready); end
        if (led_en6 !== 6'h3f) begin n_fail++; $display("FAIL reset_led_en6: got %h required 3f", led_en6); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks += 3;
        if (data_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b required 1", data_ready); end
        if (data_ready6 !== 1'b1) begin n_fail++; $display("FAIL idle_ready6: got %b required 1", data_ready6); end
        if (led_en !== 8'hff) begin n_fail++; $display("FAIL off_led_en: got %h required ff", led_en); end
    endtask

    // Hex value loaded while off, then exact scan timing after start
    task automatic test_hex();
        logic [7:0] hx8 [8] = '{8'ha1, 8'hc6, 8'h83, 8'h88, 8'h99, 8'hb0, 8'ha4, 8'hf9};
        logic [7:0] hx6 [6] = '{8'ha1, 8'hc6, 8'h83, 8'h88, 8'h99, 8'hb0};
        int p, p6;
        send(32'h1234ABCD, 1'b0);
        n_checks++;
        if (led_en !== 8'hff) begin n_fail++; $display("FAIL hex_still_off: got %h required ff", led_en); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (led_en !== 8'hff) begin n_fail++; $display("FAIL start_edge_off: got %h required ff", led_en); end
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            p  = ((k - 1) / 5) % 8;
            p6 = ((k - 1) / 5) % 6;
            n_checks += 4;
            if (led_en !== ~(8'(1) << p)) begin n_fail++; $display("FAIL hex_led_en k=%0d: got %h required %h", k, led_en, ~(8'(1) << p)); end
            if (led_w !== hx8[p]) begin n_fail++; $display("FAIL hex_led_w k=%0d: got %h required %h", k, led_w, hx8[p]); end
            if (led_en6 !== ~(6'(1) << p6)) begin n_fail++; $display("FAIL scan6_led_en k=%0d: got %b required %b", k, led_en6, ~(6'(1) << p6)); end
            if (led_w6 !== hx6[p6]) begin n_fail++; $display("FAIL scan6_led_w k=%0d: got %h required %h", k, led_w6, hx6[p6]); end
        end
    endtask

    task automatic test_decimal();
        logic [7:0] dc8 [8] = '{8'h80, 8'hf8, 8'h82, 8'h92, 8'h99, 8'hb0, 8'ha4, 8'hf9};
        int n;
        send(32'd12345678, 1'b1);
        n = 0;
        while (!data_ready && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (n != 33) begin n_fail++; $display("FAIL dec_busy_cycles: got %0d required 33", n); end
        @(posedge clk); #1;
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (seen8[i] !== dc8[i]) begin n_fail++; $display("FAIL dec_digit%0d: got %h required %h", i, seen8[i], dc8[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (seen6[i] !== 8'hbf) begin n_fail++; $display("FAIL dec6_ovf_digit%0d: got %h required bf", i, seen6[i]); end
        end
    endtask

    task automatic test_overflow();
        send(32'd99999999, 1'b1);
        wait_ready();
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (seen8[i] !== 8'h98) begin n_fail++; $display("FAIL max_digit%0d: got %h required 98", i, seen8[i]); end
        end
        send(32'd100000000, 1'b1);
        wait_ready();
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (seen8[i] !== 8'hbf) begin n_fail++; $display("FAIL ovf_digit%0d: got %h required bf", i, seen8[i]); end
        end
    endtask

    task automatic test_blanking();
        send(32'd42, 1'b1);
        wait_ready();
        capture();
        n_checks += 2;
        if (seen8[0] !== 8'ha4) begin n_fail++; $display("FAIL d42_digit0: got %h required a4", seen8[0]); end
        if (seen8[1] !== 8'h99) begin n_fail++; $display("FAIL d42_digit1: got %h required 99", seen8[1]); end
        for (int i = 2; i < 8; i++) begin
            n_checks++;
            if (seen8[i] !== LZ) begin n_fail++; $display("FAIL d42_digit%0d: got %h required %h", i, seen8[i], LZ); end
        end
        send(32'd0, 1'b1);
        wait_ready();
        capture();
        n_checks++;
        if (seen8[0] !== 8'hc0) begin n_fail++; $display("FAIL zero_digit0: got %h required c0", seen8[0]); end
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (seen8[i] !== LZ) begin n_fail++; $display("FAIL zero_digit%0d: got %h required %h", i, seen8[i], LZ); end
        end
    endtask

    task automatic test_lock_abort();
        send(32'd12345678, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        n_checks += 2;
        if (data_ready !== 1'b0) begin n_fail++; $display("FAIL conv_ready: got %b required 0", data_ready); end
        if (led_en === 8'hff) begin n_fail++; $display("FAIL display_on_before_drop: got %h required not ff", led_en); end
        locked = 1'b0;
        @(posedge clk); #1;
        n_checks += 4;
        if (led_en !== 8'hff) begin n_fail++; $display("FAIL drop_led_en: got %h required ff", led_en); end
        if (led_w !== 8'hff) begin n_fail++; $display("FAIL drop_led_w: got %h required ff", led_w); end
        if (led_en6 !== 6'h3f) begin n_fail++; $display("FAIL drop_led_en6: got %h required 3f", led_en6); end
        if (data_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b required 0", data_ready); end
        start = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            n_checks += 2;
            if (data_ready !== 1'b0) begin n_fail++; $display("FAIL unlocked_ready: got %b required 0", data_ready); end
            if (led_en !== 8'hff) begin n_fail++; $display("FAIL unlocked_start_led_en: got %h required ff", led_en); end
        end
        start = 1'b0;
        locked = 1'b1;
        @(posedge clk); #1;
        n_checks += 2;
        if (data_ready !== 1'b1) begin n_fail++; $display("FAIL relock_ready: got %b required 1", data_ready); end
        if (led_en !== 8'hff) begin n_fail++; $display("FAIL relock_off: got %h required ff", led_en); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (seen8[i] !== 8'hc0) begin n_fail++; $display("FAIL abort_digit%0d: got %h required c0", i, seen8[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (seen6[i] !== 8'hc0) begin n_fail++; $display("FAIL abort6_digit%0d: got %h required c0", i, seen6[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_blanking();
        test_lock_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
